// File: rtl/compare_output_fsm.sv
// Output-compare pulse generator: per-channel delayed pulse,
// one-shot or periodic, with start/stop control and live counter.
module compare_output_fsm #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CHANNELS    = 10
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_CHANNELS-1:0]                start_i,
  input  logic [NB_CHANNELS-1:0]                stop_i,
  input  logic [NB_CHANNELS-1:0]                periodic_i,
  input  logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] delay_i,
  input  logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] width_i,
  output logic [NB_CHANNELS-1:0]                out_o,
  output logic [NB_CHANNELS-1:0]                busy_o,
  output logic [NB_CHANNELS-1:0]                done_o,
  output logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] counter_o
);

  localparam int W = TIMER_BITWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

  for (genvar g = 0; g < NB_CHANNELS; g++) begin : g_ch
    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   dly_q, dly_d;
    logic [W-1:0]   wid_q, wid_d;
    logic [W-1:0]   wlast;
    logic           per_q, per_d;
    logic           out_q, out_d;
    logic           done_q, done_d;

    // Last pulse count; a zero width still yields a one-cycle pulse.
    assign wlast = (wid_q == '0) ? '0 : wid_q - W'(1);

    // Channel state register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        dly_q   <= '0;
        wid_q   <= '0;
        per_q   <= 1'b0;
        out_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dly_q   <= dly_d;
        wid_q   <= wid_d;
        per_q   <= per_d;
        out_q   <= out_d;
        done_q  <= done_d;
      end
    end

    // Next state: stop beats start beats normal sequencing.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      per_d   = per_q;
      out_d   = out_q;
      done_d  = 1'b0;
      if (stop_i[g]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end else if (start_i[g]) begin
        dly_d   = delay_i[g*W +: W];
        wid_d   = width_i[g*W +: W];
        per_d   = periodic_i[g];
        cnt_d   = '0;
        out_d   = 1'b0;
        state_d = ST_DELAY;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_d = '0;
            out_d = 1'b0;
          end
          ST_DELAY: begin
            if (cnt_q == dly_q) begin
              out_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_PULSE;
            end else begin
              cnt_d = cnt_q + W'(1);
            end
          end
          ST_PULSE: begin
            if (cnt_q == wlast) begin
              out_d = 1'b0;
              cnt_d = '0;
              if (per_q) begin
                state_d = ST_DELAY;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
          end
        endcase
      end
    end

    assign out_o[g]              = out_q;
    assign busy_o[g]             = (state_q == ST_DELAY) ||
                                   (state_q == ST_PULSE);
    assign done_o[g]             = done_q;
    assign counter_o[g*W +: W]   = cnt_q;
  end

endmodule

// File: tb/tb_compare_output_fsm.sv
// Scoreboard bench for compare_output_fsm: a timeline model predicts
// every channel's out/busy/done/counter after each clock edge.
module tb_compare_output_fsm;

  localparam int W = 32;
  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   start, stop, per;
  logic [W*N-1:0] delay, width;
  logic [N-1:0]   out, busy, done;
  logic [W*N-1:0] counter;
  logic [W-1:0]   dly_a [N];
  logic [W-1:0]   wid_a [N];

  compare_output_fsm #(.TIMER_BITWIDTH(W), .NB_CHANNELS(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .periodic_i(per), .delay_i(delay), .width_i(width),
    .out_o(out), .busy_o(busy), .done_o(done), .counter_o(counter)
  );

  always #5 clk = ~clk;

  always @* begin
    for (int i = 0; i < N; i++) begin
      delay[i*W +: W] = dly_a[i];
      width[i*W +: W] = wid_a[i];
    end
  end

  typedef struct packed {
    logic [N-1:0]   o;
    logic [N-1:0]   b;
    logic [N-1:0]   d;
    logic [W*N-1:0] c;
  } exp_t;

  exp_t   q[$];
  exp_t   last;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Model: a channel is a start time plus latched parameters; the
  // outputs follow from the number of edges elapsed since the start.
  bit     act [N];
  longint ts  [N];
  longint md  [N];
  longint mw  [N];
  bit     mp  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) act[i] = 1'b0;
  endtask

  task automatic step();
    exp_t   e;
    longint k, j, p, cv;
    @(posedge clk);
    cyc++;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (stop[i]) begin
        act[i] = 1'b0;
      end else if (start[i]) begin
        act[i] = 1'b1;
        ts[i]  = cyc;
        md[i]  = longint'(dly_a[i]);
        mw[i]  = (wid_a[i] == 0) ? 1 : longint'(wid_a[i]);
        mp[i]  = per[i];
      end
      if (act[i]) begin
        k = cyc - ts[i];
        p = md[i] + 1 + mw[i];
        if (!mp[i] && k > md[i] + mw[i]) begin
          act[i] = 1'b0;
          e.d[i] = (k == md[i] + mw[i] + 1);
        end else begin
          j = mp[i] ? (k % p) : k;
          e.b[i] = 1'b1;
          if (j <= md[i]) begin
            cv = j;
          end else begin
            e.o[i] = 1'b1;
            cv = j - md[i] - 1;
          end
          e.c[i*W +: W] = W'(cv);
        end
      end
    end
    q.push_back(e);
    last = e;
    #1;
    start = '0;
    stop  = '0;
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 4;
      if (out !== e.o) begin
        errors++;
        $display("FAIL out cyc=%0d got %b exp %b", cyc, out, e.o);
      end
      if (busy !== e.b) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, e.b);
      end
      if (done !== e.d) begin
        errors++;
        $display("FAIL done cyc=%0d got %b exp %b", cyc, done, e.d);
      end
      if (counter !== e.c) begin
        errors++;
        $display("FAIL counter cyc=%0d got %h exp %h", cyc, counter, e.c);
      end
    end
  end

  task automatic check_zero(string nm);
    checks += 4;
    if (out !== '0) begin
      errors++;
      $display("FAIL %s out got %b exp 0", nm, out);
    end
    if (busy !== '0) begin
      errors++;
      $display("FAIL %s busy got %b exp 0", nm, busy);
    end
    if (done !== '0) begin
      errors++;
      $display("FAIL %s done got %b exp 0", nm, done);
    end
    if (counter !== '0) begin
      errors++;
      $display("FAIL %s counter got %h exp 0", nm, counter);
    end
  endtask

  task automatic set_ch(int i, int d, int w, bit p);
    dly_a[i] = W'(d);
    wid_a[i] = W'(w);
    per[i]   = p;
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    stop  = '0;
    per   = '0;
    for (int i = 0; i < N; i++) begin
      dly_a[i] = '0;
      wid_a[i] = '0;
    end
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    // Concurrent directed scenarios on ch0..ch4 and ch9.
    set_ch(0, 3, 2, 1'b0);
    set_ch(1, 0, 0, 1'b1);
    set_ch(2, 5, 3, 1'b1);
    set_ch(3, 10, 4, 1'b0);
    set_ch(4, 4, 2, 1'b0);
    set_ch(9, 7, 1, 1'b1);
    start = 10'b10_0001_1111;
    step();
    repeat (6) step();
    start[3] = 1'b1;
    dly_a[4] = 32'd20;
    step();
    repeat (30) step();
    for (int n = 0; n < 20 && !last.o[2]; n++) step();
    stop[2] = 1'b1;
    step();
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    step();
    repeat (5) step();

    // Asynchronous reset with every channel mid-pulse.
    for (int i = 0; i < N; i++) set_ch(i, 0, 5, 1'b0);
    start = '1;
    step();
    step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    start[5] = 1'b1;
    step();
    repeat (8) step();

    // Random starts/stops with parameters churning underneath.
    repeat (600) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_ch(i, $urandom_range(0, 12), $urandom_range(0, 6),
                 1'($urandom_range(0, 1)));
        start[i] = ($urandom_range(0, 15) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
      end
      step();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
